// File: rtl/hamming_pkg.sv
// Shared constants, scheduler state type and position helpers for the
// 32->38-bit Hamming SEC encoder.
package hamming_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ENC_W     = 38;
  localparam int unsigned PARITY_W  = 6;
  localparam int unsigned ENC_IDX_W = 6;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } sched_state_e;

  // Parity bit k lives at codeword position 2^k - 1.
  function automatic int unsigned parity_pos(int unsigned k);
    return (32'd1 << k) - 32'd1;
  endfunction

  // Data bit i goes to the i-th non-parity position, ascending.
  function automatic int unsigned data_pos(int unsigned bit_idx);
    int unsigned n;
    data_pos = 0;
    n        = 0;
    for (int unsigned q = 0; q < ENC_W; q++) begin
      if (((q + 1) & q) != 0) begin
        if (n == bit_idx) data_pos = q;
        n++;
      end
    end
  endfunction

endpackage

// File: rtl/hamming_enc_word.sv
// Combinational single-word Hamming SEC encoder: scatter data bits, then
// fill each parity bit with the even XOR of the positions it covers.
module hamming_enc_word
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [ENC_W-1:0]  code
);

  always_comb begin
    logic par;
    code = '0;
    par  = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      code[ENC_IDX_W'(data_pos(i))] = data[i];
    end
    // Parity positions are still zero here, so they drop out of each XOR.
    for (int unsigned k = 0; k < PARITY_W; k++) begin
      par = 1'b0;
      for (int unsigned p = 0; p < ENC_W; p++) begin
        if ((((p + 1) >> k) & 1) != 0) par = par ^ code[ENC_IDX_W'(p)];
      end
      code[ENC_IDX_W'(parity_pos(k))] = par;
    end
  end

endmodule

// File: rtl/hamming_frame_sched.sv
// Frame-granular round-robin scheduler feeding NREQ word streams through one
// shared Hamming encoder into a registered, backpressured output stage.
module hamming_frame_sched
  import hamming_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = 32,
  parameter int unsigned NREQ            = 2,
  localparam int unsigned SRC_W          = $clog2(NREQ),
  localparam int unsigned IDX_W          = $clog2(WORDS_PER_FRAME)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        in_valid,
  output logic [NREQ-1:0]        in_ready,
  input  logic [NREQ*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ENC_W-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS_PER_FRAME - 1);
  localparam logic [SRC_W-1:0] LastReq = SRC_W'(NREQ - 1);

  sched_state_e     state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] word_cnt_q, word_cnt_d;

  logic             out_valid_q;
  logic [ENC_W-1:0] out_data_q;
  logic [SRC_W-1:0] out_src_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_last_q;

  logic              any_valid;
  logic [SRC_W-1:0]  arb_pick;
  logic              gnt_valid;
  logic [DATA_W-1:0] gnt_data;
  logic [ENC_W-1:0]  gnt_code;
  logic              can_load;
  logic              accept;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    any_valid = 1'b0;
    arb_pick  = '0;
    cand      = 0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      cand = int'(rr_ptr_q) + j;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_valid && in_valid[SRC_W'(cand)]) begin
        any_valid = 1'b1;
        arb_pick  = SRC_W'(cand);
      end
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == SRC_W'(i)) begin
        gnt_valid = in_valid[i];
        gnt_data  = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  hamming_enc_word u_enc (
    .data (gnt_data),
    .code (gnt_code)
  );

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    in_ready   = '0;
    accept     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          grant_d = arb_pick;
          state_d = StStream;
        end
      end
      StStream: begin
        in_ready[grant_q] = can_load;
        accept            = gnt_valid && can_load;
        if (accept) begin
          if (word_cnt_q == LastIdx) begin
            state_d    = StIdle;
            rr_ptr_d   = (grant_q == LastReq) ? '0 : grant_q + 1'b1;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Fields only change on a load, so they hold through a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt_code;
      out_src_q   <= grant_q;
      out_idx_q   <= word_cnt_q;
      out_last_q  <= (word_cnt_q == LastIdx);
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == StStream) || out_valid_q;

endmodule

// File: tb/tb_hamming_frame_sched.sv
// Directed bench for hamming_frame_sched: arbitration, framing, backpressure,
// asynchronous reset and encoder correctness.
module tb_hamming_frame_sched;

  localparam int NREQ = 2;
  localparam int WPF  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] out_data;
  logic [0:0]  out_src;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  hamming_frame_sched #(
    .WORDS_PER_FRAME (WPF),
    .NREQ            (NREQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [37:0] enc_model(input logic [31:0] d);
    logic [37:0] c;
    logic        x;
    int          j;
    c = '0;
    j = 0;
    for (int p = 0; p < 38; p++) begin
      if (((p + 1) & p) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      x = 1'b0;
      for (int p = 0; p < 38; p++) if (((p + 1) & (1 << k)) != 0) x ^= c[p];
      c[(1 << k) - 1] = x;
    end
    return c;
  endfunction

  function automatic logic [5:0] syndrome(input logic [37:0] c);
    logic [5:0] s;
    s = '0;
    for (int k = 0; k < 6; k++)
      for (int p = 0; p < 38; p++) if (((p + 1) & (1 << k)) != 0) s[k] ^= c[p];
    return s;
  endfunction

  function automatic int tb_data_pos(input int i);
    int n;
    n = 0;
    for (int p = 0; p < 38; p++) begin
      if (((p + 1) & p) != 0) begin
        if (n == i) return p;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic logic [37:0] hand_val(input int w);
    case (w)
      0:       return 38'h0;
      1:       return 38'h7;
      default: return 38'h19;
    endcase
  endfunction

  function automatic logic [31:0] gen(input int mode, input int req, input int w);
    case (mode)
      0:       return 32'((req << 16) | w);
      1:       return 32'd1 << w;
      default: return $urandom();
    endcase
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Streams nwords of one frame from req; mode 0 index, 1 one-hot, 2 random.
  task automatic drive_frame(input int req, input int nwords, input int mode, input bit toggle);
    int          w, cyc, pc;
    logic [31:0] d;
    logic [37:0] pd, exp;
    logic [4:0]  pidx;
    logic [1:0]  others;
    bit          acc, rdy, pv;
    w   = 0;
    cyc = 0;
    d   = gen(mode, req, 0);
    while (w < nwords && cyc < 400) begin
      in_valid                = '0;
      in_valid[req]           = 1'b1;
      in_data[req*32 +: 32]   = d;
      out_ready               = toggle ? ((cyc % 2) == 1) : 1'b1;
      @(negedge clk);
      acc  = in_ready[req];
      rdy  = out_ready;
      pv   = out_valid;
      pd   = out_data;
      pidx = out_idx;
      others      = in_ready;
      others[req] = 1'b0;
      checks++;
      if (others !== 2'b00) begin
        fails++;
        $display("FAIL other_ready: got %b want 00", others);
      end
      if (pv && !rdy) begin
        checks++;
        if (in_ready[req] !== 1'b0) begin
          fails++;
          $display("FAIL stall_ready: got %b want 0", in_ready[req]);
        end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        exp = enc_model(d);
        checks += 5;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("FAIL word_valid: got %b want 1", out_valid);
        end
        if (out_data !== exp) begin
          fails++;
          $display("FAIL word_data idx %0d: got %h want %h", w, out_data, exp);
        end
        if (out_src !== 1'(req)) begin
          fails++;
          $display("FAIL word_src: got %0d want %0d", out_src, req);
        end
        if (out_idx !== 5'(w)) begin
          fails++;
          $display("FAIL word_idx: got %0d want %0d", out_idx, w);
        end
        if (out_last !== (w == WPF - 1)) begin
          fails++;
          $display("FAIL word_last idx %0d: got %b want %b", w, out_last, (w == WPF - 1));
        end
        if (mode == 0 && req == 0 && w < 3) begin
          checks++;
          if (out_data !== hand_val(w)) begin
            fails++;
            $display("FAIL hand_vector %0d: got %h want %h", w, out_data, hand_val(w));
          end
        end
        if (mode == 1) begin
          pc = $countones(out_data);
          checks += 2;
          if (pc < 3) begin
            fails++;
            $display("FAIL onehot_weight bit %0d: got %0d want >=3", w, pc);
          end
          if (out_data[tb_data_pos(w)] !== 1'b1) begin
            fails++;
            $display("FAIL onehot_pos bit %0d: got %h want bit %0d set", w, out_data,
                     tb_data_pos(w));
          end
        end
        if (mode == 2) begin
          checks++;
          if (syndrome(out_data) !== 6'd0) begin
            fails++;
            $display("FAIL syndrome: got %h want 00 for %h", syndrome(out_data), out_data);
          end
        end
        w++;
        d = gen(mode, req, w);
      end else if (pv && !rdy) begin
        checks += 3;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("FAIL stall_valid: got %b want 1", out_valid);
        end
        if (out_data !== pd) begin
          fails++;
          $display("FAIL stall_data: got %h want %h", out_data, pd);
        end
        if (out_idx !== pidx) begin
          fails++;
          $display("FAIL stall_idx: got %0d want %0d", out_idx, pidx);
        end
      end
      cyc++;
    end
    in_valid  = '0;
    out_ready = 1'b1;
    checks++;
    if (w < nwords) begin
      fails++;
      $display("FAIL frame_timeout: got %0d words want %0d", w, nwords);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 2'b11;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 7;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    if (out_data !== 38'h0) begin fails++; $display("FAIL rst_data: got %h want 0", out_data); end
    if (out_src !== 1'b0) begin fails++; $display("FAIL rst_src: got %0d want 0", out_src); end
    if (out_idx !== 5'd0) begin fails++; $display("FAIL rst_idx: got %0d want 0", out_idx); end
    if (out_last !== 1'b0) begin fails++; $display("FAIL rst_last: got %b want 0", out_last); end
    if (in_ready !== 2'b00) begin fails++; $display("FAIL rst_ready: got %b want 00", in_ready); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    in_valid = '0;
  endtask

  task automatic test_full_frame();
    do_reset();
    drive_frame(0, WPF, 0, 1'b0);
    checks += 2;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_tail: got %b want 1", busy); end
    if (out_last !== 1'b1) begin fails++; $display("FAIL last_hold: got %b want 1", out_last); end
    @(posedge clk);
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin fails++; $display("FAIL drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int          cnt [2];
    int          total, cyc, owner;
    bit          bubble;
    logic [1:0]  r;
    logic [31:0] d;
    do_reset();
    cnt[0] = 0;
    cnt[1] = 0;
    total  = 0;
    cyc    = 0;
    bubble = 1'b1;
    in_valid = 2'b11;
    while (total < 3 * WPF && cyc < 400) begin
      in_data[31:0]  = gen(0, 0, cnt[0]);
      in_data[63:32] = gen(0, 1, cnt[1]);
      owner = (total / WPF) % 2;
      d     = gen(0, owner, cnt[owner]);
      @(negedge clk);
      r = in_ready;
      checks++;
      if (r[1 - owner] !== 1'b0) begin
        fails++;
        $display("FAIL b2b_nonowner: got %b want req%0d low", r, 1 - owner);
      end
      if (bubble) begin
        checks++;
        if (r !== 2'b00) begin fails++; $display("FAIL b2b_bubble: got %b want 00", r); end
        bubble = 1'b0;
      end
      @(posedge clk);
      #1;
      if (r[owner] === 1'b1) begin
        checks += 3;
        if (out_src !== 1'(owner)) begin
          fails++;
          $display("FAIL b2b_src: got %0d want %0d", out_src, owner);
        end
        if (out_idx !== 5'(cnt[owner] % WPF)) begin
          fails++;
          $display("FAIL b2b_idx: got %0d want %0d", out_idx, cnt[owner] % WPF);
        end
        if (out_data !== enc_model(d)) begin
          fails++;
          $display("FAIL b2b_data: got %h want %h", out_data, enc_model(d));
        end
        if ((cnt[owner] % WPF) == WPF - 1) bubble = 1'b1;
        cnt[owner]++;
        total++;
      end
      cyc++;
    end
    in_valid = '0;
    checks++;
    if (cyc !== 3 * (WPF + 1)) begin
      fails++;
      $display("FAIL b2b_cycles: got %0d want %0d", cyc, 3 * (WPF + 1));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_frame(0, WPF, 0, 1'b1);
  endtask

  task automatic test_bit_positions();
    do_reset();
    drive_frame(0, WPF, 1, 1'b0);
  endtask

  task automatic test_random_syndrome();
    do_reset();
    for (int f = 0; f < 32; f++) drive_frame(f % 2, WPF, 2, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    drive_frame(0, 10, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    if (out_data !== 38'h0) begin fails++; $display("FAIL mid_rst_data: got %h want 0", out_data); end
    if (out_idx !== 5'd0) begin fails++; $display("FAIL mid_rst_idx: got %0d want 0", out_idx); end
    if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    if (in_ready !== 2'b00) begin fails++; $display("FAIL mid_rst_ready: got %b want 00", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_frame(1, WPF, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_backpressure();
    test_bit_positions();
    test_random_syndrome();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
